// File: rtl/uart_rx.sv
// UART 8N1 receiver: recovers bytes from an asynchronous serial line.
// Latency: strobe 3 + HALF_CNT + 9*BAUD_CNT clocks after the start-bit falling edge.
// No backpressure: rx_done/rx_err are single-cycle strobes; rx_data holds the last good byte.
module uart_rx #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_done,
   output logic       rx_err,
   output logic       rx_busy
);

   localparam int BAUD_CNT = CLK_FREQ / BAUD;
   localparam int HALF_CNT = BAUD_CNT / 2;
   localparam int CNT_W    = (BAUD_CNT > 2) ? $clog2(BAUD_CNT) : 1;

   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(BAUD_CNT - 1);
   localparam logic [CNT_W-1:0] LAST_HALF = CNT_W'(HALF_CNT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           state_q;
   logic             sync1_q;
   logic             sync_q;
   logic             sync_prev_q;
   logic [1:0]       vld_q;
   logic             arm_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [2:0]       bit_q;
   logic [7:0]       shift_q;
   logic [7:0]       data_q;
   logic             done_q;
   logic             err_q;
   logic             busy_q;
   logic             start_edge;

   // Synchroniser, edge history, and an arm flag. The synchroniser resets to
   // idle-high, so releasing reset while the line is low would otherwise look
   // like a start edge in the middle of a frame. arm_q stays low until a real
   // (post-reset) high sample has passed through, discarding that partial frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q     <= 1'b1;
         sync_q      <= 1'b1;
         sync_prev_q <= 1'b1;
         vld_q       <= 2'b00;
         arm_q       <= 1'b0;
      end else begin
         sync1_q     <= rx;
         sync_q      <= sync1_q;
         sync_prev_q <= sync_q;
         vld_q       <= {vld_q[0], 1'b1};
         arm_q       <= arm_q | (vld_q[1] & sync_q);
      end
   end

   assign start_edge = arm_q & sync_prev_q & ~sync_q;
   assign cnt_d      = cnt_q + CNT_W'(1);

   // Frame FSM: half-bit wait to the start-bit centre, then one sample per bit period.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (start_edge) begin
                  state_q <= START;
                  busy_q  <= 1'b1;
               end
            end
            START: begin
               if (cnt_q == LAST_HALF) begin
                  cnt_q <= '0;
                  bit_q <= '0;
                  if (sync_q) begin
                     // Line already high again at mid start bit: a glitch.
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= DATA;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            DATA: begin
               if (cnt_q == LAST_BIT) begin
                  cnt_q   <= '0;
                  shift_q <= {sync_q, shift_q[7:1]};
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     state_q <= STOP;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            STOP: begin
               if (cnt_q == LAST_BIT) begin
                  // Leave at mid stop bit so a back-to-back start bit is caught.
                  cnt_q   <= '0;
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  if (sync_q) begin
                     data_q <= shift_q;
                     done_q <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign rx_data = data_q;
   assign rx_done = done_q;
   assign rx_err  = err_q;
   assign rx_busy = busy_q;

endmodule
